myseg_axil_slave: RTL and testbench

AXI4-Lite slave responder for the seven-segment display IP. It accepts single-beat register writes and reads from an AXI4-Lite master, such as the master VIP used in block-level benches. It holds four 32-bit R/W registers and drives a time-multiplexed, active-low seven-segment display from them. Sits between the PS/interconnect AXI4-Lite port and the board display pins.

---
 rtl/myseg_axil_slave.sv | 257 +++++++++++++++++++++++++
 tb/tb_myseg_axil_slave.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/myseg_axil_slave.sv
// -----------------------------------------------------------------------------
// myseg_axil_slave
//
// AXI4-Lite slave for the seven-segment display IP. It holds four 32-bit
// read/write registers and drives a time-multiplexed, active-low display from
// them.
//
// Register map (decoded from ADDR[3:2]; ADDR[1:0] and upper bits alias):
//   0 DATA    : digit k shows DATA[4k+3:4k]
//   1 CTRL    : bit0 EN, bits[15:8] decimal-point mask (bit 8+k = DP on digit k)
//   2 DIV     : scan counter reload value (bits[23:0] used)
//   3 SCRATCH : general purpose
//
// Handshake rule (all five channels): a transfer happens on a rising clock
// edge where both VALID and READY are high. This slave asserts its READYs
// only as registered one-cycle pulses. BVALID/RVALID, once raised, stay high
// with stable payload until the master's READY is seen.
//
// Ports:
//   ACLK, ARESET         clock, synchronous active-high reset
//   S_AXI_AW*/W*/B*      write address / data / response channels
//   S_AXI_AR*/R*         read address / data channels
//   SEG[6:0]             segments {g,f,e,d,c,b,a}, active-low
//   DP                   decimal point, active-low
//   AN[NUM_DIGITS-1:0]   digit anodes, active-low one-hot
// -----------------------------------------------------------------------------
module myseg_axil_slave #(
    parameter int NUM_DIGITS         = 4,
    parameter int C_S_AXI_ADDR_WIDTH = 4,
    parameter int C_S_AXI_DATA_WIDTH = 32
) (
    input  logic                            ACLK,
    input  logic                            ARESET,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
    input  logic [2:0]                      S_AXI_AWPROT,
    input  logic                            S_AXI_AWVALID,
    output logic                            S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
    input  logic                            S_AXI_WVALID,
    output logic                            S_AXI_WREADY,
    output logic [1:0]                      S_AXI_BRESP,
    output logic                            S_AXI_BVALID,
    input  logic                            S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
    input  logic [2:0]                      S_AXI_ARPROT,
    input  logic                            S_AXI_ARVALID,
    output logic                            S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
    output logic [1:0]                      S_AXI_RRESP,
    output logic                            S_AXI_RVALID,
    input  logic                            S_AXI_RREADY,
    output logic [6:0]                      SEG,
    output logic                            DP,
    output logic [NUM_DIGITS-1:0]           AN
);

    localparam int DW = C_S_AXI_DATA_WIDTH;
    localparam int SW = C_S_AXI_DATA_WIDTH / 8;

    // ------------------------------------------------------------------
    // Register file
    // ------------------------------------------------------------------
    logic [DW-1:0] reg_data;
    logic [DW-1:0] reg_ctrl;
    logic [DW-1:0] reg_div;
    logic [DW-1:0] reg_scratch;

    // Byte-lane merge of new write data into an existing register value.
    function automatic logic [DW-1:0] merge_strb(input logic [DW-1:0] old_val,
                                                 input logic [DW-1:0] new_val,
                                                 input logic [SW-1:0] strb);
        logic [DW-1:0] res;
        res = old_val;
        for (int b = 0; b < SW; b++) begin
            if (strb[b]) res[8*b +: 8] = new_val[8*b +: 8];
        end
        return res;
    endfunction

    // ------------------------------------------------------------------
    // Write channel
    // AWREADY and WREADY are one shared register: both addresses and data
    // must be present before either is accepted, so they pulse together.
    // ------------------------------------------------------------------
    logic wr_ready;
    logic bvalid_q;
    logic wr_fire;

    assign wr_fire = wr_ready & S_AXI_AWVALID & S_AXI_WVALID;

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            wr_ready <= 1'b0;
            bvalid_q <= 1'b0;
        end else begin
            wr_ready <= S_AXI_AWVALID & S_AXI_WVALID & ~wr_ready & ~bvalid_q;
            if (wr_fire) begin
                bvalid_q <= 1'b1;
            end else if (bvalid_q & S_AXI_BREADY) begin
                bvalid_q <= 1'b0;
            end
        end
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            reg_data    <= '0;
            reg_ctrl    <= '0;
            reg_div     <= '0;
            reg_scratch <= '0;
        end else if (wr_fire) begin
            case (S_AXI_AWADDR[3:2])
                2'd0: reg_data    <= merge_strb(reg_data,    S_AXI_WDATA, S_AXI_WSTRB);
                2'd1: reg_ctrl    <= merge_strb(reg_ctrl,    S_AXI_WDATA, S_AXI_WSTRB);
                2'd2: reg_div     <= merge_strb(reg_div,     S_AXI_WDATA, S_AXI_WSTRB);
                default: reg_scratch <= merge_strb(reg_scratch, S_AXI_WDATA, S_AXI_WSTRB);
            endcase
        end
    end

    assign S_AXI_AWREADY = wr_ready;
    assign S_AXI_WREADY  = wr_ready;
    assign S_AXI_BVALID  = bvalid_q;
    assign S_AXI_BRESP   = 2'b00;

    // ------------------------------------------------------------------
    // Read channel
    // RDATA is captured in the address handshake cycle, so a write landing
    // on the same edge is not yet visible (old value returned).
    // ------------------------------------------------------------------
    logic          arready_q;
    logic          rvalid_q;
    logic [DW-1:0] rdata_q;
    logic [DW-1:0] rd_mux;
    logic          ar_fire;

    assign ar_fire = arready_q & S_AXI_ARVALID;

    always_comb begin
        rd_mux = '0;
        case (S_AXI_ARADDR[3:2])
            2'd0:    rd_mux = reg_data;
            2'd1:    rd_mux = reg_ctrl;
            2'd2:    rd_mux = reg_div;
            default: rd_mux = reg_scratch;
        endcase
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
        end else begin
            arready_q <= S_AXI_ARVALID & ~arready_q & ~rvalid_q;
            if (ar_fire) begin
                rdata_q  <= rd_mux;
                rvalid_q <= 1'b1;
            end else if (rvalid_q & S_AXI_RREADY) begin
                rvalid_q <= 1'b0;
            end
        end
    end

    assign S_AXI_ARREADY = arready_q;
    assign S_AXI_RVALID  = rvalid_q;
    assign S_AXI_RDATA   = rdata_q;
    assign S_AXI_RRESP   = 2'b00;

    // ------------------------------------------------------------------
    // Scan timing: down-counter reloads from DIV when it hits zero and that
    // zero cycle is the tick. A new DIV only matters at the next reload.
    // ------------------------------------------------------------------
    logic [23:0] scan_cnt;
    logic [2:0]  digit_idx;
    logic        tick;

    assign tick = (scan_cnt == 24'd0);

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            scan_cnt  <= '0;
            digit_idx <= '0;
        end else begin
            if (tick) begin
                scan_cnt <= reg_div[23:0];
                if (digit_idx == 3'(NUM_DIGITS - 1)) begin
                    digit_idx <= '0;
                end else begin
                    digit_idx <= digit_idx + 3'd1;
                end
            end else begin
                scan_cnt <= scan_cnt - 24'd1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Display outputs (registered from the current digit index)
    // ------------------------------------------------------------------
    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'h0: s = 7'h40;
            4'h1: s = 7'h79;
            4'h2: s = 7'h24;
            4'h3: s = 7'h30;
            4'h4: s = 7'h19;
            4'h5: s = 7'h12;
            4'h6: s = 7'h02;
            4'h7: s = 7'h78;
            4'h8: s = 7'h00;
            4'h9: s = 7'h10;
            4'hA: s = 7'h08;
            4'hB: s = 7'h03;
            4'hC: s = 7'h46;
            4'hD: s = 7'h21;
            4'hE: s = 7'h06;
            default: s = 7'h0E;
        endcase
        return s;
    endfunction

    logic                  disp_en;
    logic [3:0]            cur_nib;
    logic [7:0]            dp_mask;
    logic [NUM_DIGITS-1:0] an_sel;

    assign disp_en = reg_ctrl[0];
    assign cur_nib = reg_data[{digit_idx, 2'b00} +: 4];
    assign dp_mask = reg_ctrl[15:8];
    assign an_sel  = NUM_DIGITS'(1) << digit_idx;

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            SEG <= 7'h7F;
            DP  <= 1'b1;
            AN  <= '1;
        end else if (disp_en) begin
            SEG <= hex_to_seg(cur_nib);
            DP  <= ~dp_mask[digit_idx];
            AN  <= ~an_sel;
        end else begin
            SEG <= 7'h7F;
            DP  <= 1'b1;
            AN  <= '1;
        end
    end

    // Inputs and register bits that carry no function in this block.
    logic unused_bits;
    assign unused_bits = ^{S_AXI_AWPROT, S_AXI_ARPROT,
                           S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0],
                           reg_div[DW-1:24], reg_ctrl[DW-1:16], reg_ctrl[7:1]};

endmodule

// File: tb/tb_myseg_axil_slave.sv
module tb_myseg_axil_slave;

    // ---------------- clock / reset ----------------
    logic clk;
    logic areset;
    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [3:0]  awaddr, araddr;
    logic [2:0]  awprot, arprot;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rvalid, rready;
    logic [31:0] wdata, rdata;
    logic [3:0]  wstrb;
    logic [1:0]  bresp, rresp;
    logic [6:0]  seg;
    logic        dp;
    logic [3:0]  an;

    myseg_axil_slave #(.NUM_DIGITS(4), .C_S_AXI_ADDR_WIDTH(4), .C_S_AXI_DATA_WIDTH(32)) dut (
        .ACLK(clk), .ARESET(areset),
        .S_AXI_AWADDR(awaddr), .S_AXI_AWPROT(awprot), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
        .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
        .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
        .S_AXI_ARADDR(araddr), .S_AXI_ARPROT(arprot), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
        .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready),
        .SEG(seg), .DP(dp), .AN(an)
    );

    // ---------------- reference model + scoreboard ----------------
    int n_checks = 0;
    int n_errors = 0;
    logic [31:0] model [4];
    logic [31:0] exp_q [$];
    logic [6:0]  hex_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                  7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        n_checks++;
        n_errors++;
        $display("FAIL %s: no handshake within cycle budget", name);
    endtask

    task automatic model_clear();
        for (int i = 0; i < 4; i++) model[i] = 32'h0;
    endtask

    task automatic model_write(input logic [3:0] addr, input logic [31:0] data, input logic [3:0] strb);
        for (int b = 0; b < 4; b++)
            if (strb[b]) model[addr[3:2]][8*b +: 8] = data[8*b +: 8];
    endtask

    // ---------------- driver tasks ----------------
    task automatic do_reset();
        areset = 1'b1;
        repeat (2) @(posedge clk);
        #1 areset = 1'b0;
        model_clear();
    endtask

    task automatic axi_write(input logic [3:0] addr, input logic [31:0] data, input logic [3:0] strb);
        int n;
        awaddr = addr; wdata = data; wstrb = strb;
        awvalid = 1'b1; wvalid = 1'b1;
        n = 0;
        do begin @(posedge clk); #1; n++; end while (!awready && n < 20);
        if (!awready) begin
            timeout("wr_addr_hs");
            awvalid = 1'b0; wvalid = 1'b0;
            return;
        end
        check("wready_with_awready", {31'b0, wready}, 32'd1);
        @(posedge clk); #1;
        awvalid = 1'b0; wvalid = 1'b0;
        model_write(addr, data, strb);
        check("bvalid_after_hs", {31'b0, bvalid}, 32'd1);
        check("bresp", {30'b0, bresp}, 32'd0);
        bready = 1'b1;
        @(posedge clk); #1;
        bready = 1'b0;
        check("bvalid_cleared", {31'b0, bvalid}, 32'd0);
    endtask

    task automatic axi_read(input logic [3:0] addr, output logic [31:0] data, output bit ok);
        int n;
        ok = 1'b0; data = 32'h0;
        araddr = addr; arvalid = 1'b1;
        n = 0;
        do begin @(posedge clk); #1; n++; end while (!arready && n < 20);
        if (!arready) begin
            timeout("rd_addr_hs");
            arvalid = 1'b0;
            return;
        end
        @(posedge clk); #1;
        arvalid = 1'b0;
        if (!rvalid) begin
            timeout("rvalid");
            return;
        end
        check("rresp", {30'b0, rresp}, 32'd0);
        data = rdata;
        rready = 1'b1;
        @(posedge clk); #1;
        rready = 1'b0;
        check("rvalid_cleared", {31'b0, rvalid}, 32'd0);
        ok = 1'b1;
    endtask

    task automatic read_check(input string name, input logic [3:0] addr);
        logic [31:0] d;
        bit ok;
        exp_q.push_back(model[addr[3:2]]);
        axi_read(addr, d, ok);
        if (ok) check(name, d, exp_q.pop_front());
        else void'(exp_q.pop_front());
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [3:0]  addr;
        logic [31:0] data;
        logic [3:0]  strb;
        logic [31:0] exp;
    } vec_t;
    vec_t vecs [8];

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        logic [31:0] d;
        bit ok;
        int n;

        vecs[0] = '{4'h0, 32'h0000_0001, 4'hF, 32'h0000_0001};
        vecs[1] = '{4'h4, 32'h0000_0002, 4'hF, 32'h0000_0002};
        vecs[2] = '{4'h8, 32'h0000_0003, 4'hF, 32'h0000_0003};
        vecs[3] = '{4'hC, 32'h0000_0004, 4'hF, 32'h0000_0004};
        vecs[4] = '{4'hC, 32'h0000_0000, 4'hF, 32'h0000_0000};
        vecs[5] = '{4'hC, 32'hAABB_CCDD, 4'b0101, 32'h00BB_00DD};
        vecs[6] = '{4'h1, 32'h1234_5678, 4'b1000, 32'h1200_0001};
        vecs[7] = '{4'hE, 32'hFFFF_FFFF, 4'b0010, 32'h00BB_FFDD};

        awaddr = 0; araddr = 0; awprot = 0; arprot = 0;
        awvalid = 0; wvalid = 0; arvalid = 0; bready = 0; rready = 0;
        wdata = 0; wstrb = 0;
        model_clear();

        // ---- reset state ----
        areset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_awready", {31'b0, awready}, 0);
        check("rst_wready",  {31'b0, wready}, 0);
        check("rst_bvalid",  {31'b0, bvalid}, 0);
        check("rst_arready", {31'b0, arready}, 0);
        check("rst_rvalid",  {31'b0, rvalid}, 0);
        check("rst_rdata",   rdata, 0);
        check("rst_an",      {28'b0, an}, 32'hF);
        check("rst_seg",     {25'b0, seg}, 32'h7F);
        check("rst_dp",      {31'b0, dp}, 1);
        areset = 1'b0;
        read_check("rst_read0", 4'h0);

        // ---- table-driven write/readback ----
        for (int i = 0; i < 8; i++) begin
            axi_write(vecs[i].addr, vecs[i].data, vecs[i].strb);
            axi_read(vecs[i].addr, d, ok);
            if (ok) check($sformatf("vec%0d_readback", i), d, vecs[i].exp);
        end
        for (int i = 0; i < 4; i++) read_check($sformatf("vec_final_reg%0d", i), 4'(i * 4));

        // ---- AW before W, then held BREADY=0 ----
        awaddr = 4'hC; wdata = 32'h5A5A_0001; wstrb = 4'hF;
        awvalid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check("aw_only_no_ready", {31'b0, awready | wready}, 0);
        end
        wvalid = 1'b1;
        n = 0;
        do begin @(posedge clk); #1; n++; end while (!awready && n < 20);
        if (!awready) timeout("late_w_hs");
        check("late_w_wready", {31'b0, wready}, 1);
        @(posedge clk); #1;
        model_write(4'hC, 32'h5A5A_0001, 4'hF);
        check("late_w_single_pulse", {31'b0, awready}, 0);
        // Offer a second write while the response is pending
        wdata = 32'h0000_BEEF;
        for (int i = 0; i < 5; i++) begin
            check("bvalid_held", {31'b0, bvalid}, 1);
            check("no_accept_during_b", {31'b0, awready | wready}, 0);
            @(posedge clk); #1;
        end
        bready = 1'b1;
        @(posedge clk); #1;
        bready = 1'b0;
        check("bvalid_drop", {31'b0, bvalid}, 0);
        n = 0;
        do begin @(posedge clk); #1; n++; end while (!awready && n < 20);
        if (!awready) timeout("second_wr_hs");
        @(posedge clk); #1;
        awvalid = 1'b0; wvalid = 1'b0;
        model_write(4'hC, 32'h0000_BEEF, 4'hF);
        check("second_bvalid", {31'b0, bvalid}, 1);
        bready = 1'b1;
        @(posedge clk); #1;
        bready = 1'b0;
        read_check("second_wr_data", 4'hC);

        // ---- same-cycle read and write of one register returns old value ----
        d = model[3];
        awaddr = 4'hC; wdata = 32'hCAFE_F00D; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
        araddr = 4'hC; arvalid = 1'b1;
        @(posedge clk); #1;
        check("rw_awready", {31'b0, awready}, 1);
        check("rw_arready", {31'b0, arready}, 1);
        @(posedge clk); #1;
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
        check("rw_rvalid", {31'b0, rvalid}, 1);
        check("rw_old_value", rdata, d);
        bready = 1'b1; rready = 1'b1;
        @(posedge clk); #1;
        bready = 1'b0; rready = 1'b0;
        model_write(4'hC, 32'hCAFE_F00D, 4'hF);
        read_check("rw_new_value", 4'hC);

        // ---- randomized traffic against the model ----
        for (int i = 0; i < 60; i++) begin
            logic [3:0] a;
            a = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 1) == 0) read_check("rand_read", a);
            else axi_write(a, $urandom, 4'($urandom_range(0, 15)));
        end
        for (int i = 0; i < 4; i++) read_check("rand_final", 4'(i * 4));

        // ---- display scan ----
        do_reset();
        axi_write(4'h0, 32'h0000_3210, 4'hF);
        axi_write(4'h8, 32'h0000_0001, 4'hF);
        axi_write(4'h4, 32'h0000_0201, 4'hF);
        repeat (6) @(posedge clk);
        #1;
        begin
            int prev, run, dig, zeros, runs_seen;
            prev = -1; run = 0; runs_seen = 0;
            for (int c = 0; c < 40; c++) begin
                zeros = 0; dig = 0;
                for (int k = 0; k < 4; k++) if (!an[k]) begin zeros++; dig = k; end
                check("scan_an_onehot", zeros, 1);
                check("scan_seg", {25'b0, seg}, {25'b0, hex_tab[model[0][4*dig +: 4]]});
                check("scan_dp", {31'b0, dp}, {31'b0, ~model[1][8 + dig]});
                if (dig != prev) begin
                    if (prev >= 0) begin
                        check("scan_step", dig, (prev + 1) % 4);
                        if (runs_seen > 0) check("scan_dwell", run, 2);
                        runs_seen++;
                    end
                    prev = dig; run = 1;
                end else begin
                    run++;
                end
                @(posedge clk); #1;
            end
            check("scan_progressed", {31'b0, runs_seen > 8}, 1);
        end

        // ---- display disabled ----
        axi_write(4'h4, 32'h0000_0000, 4'hF);
        @(posedge clk); #1;
        for (int c = 0; c < 10; c++) begin
            check("dis_an", {28'b0, an}, 32'hF);
            check("dis_seg", {25'b0, seg}, 32'h7F);
            check("dis_dp", {31'b0, dp}, 1);
            @(posedge clk); #1;
        end

        // ---- reset while read response is pending ----
        araddr = 4'h0; arvalid = 1'b1;
        n = 0;
        do begin @(posedge clk); #1; n++; end while (!arready && n < 20);
        if (!arready) timeout("rst_mid_hs");
        @(posedge clk); #1;
        arvalid = 1'b0;
        check("pend_rvalid", {31'b0, rvalid}, 1);
        check("pend_rdata", rdata, 32'h0000_3210);
        @(posedge clk); #1;
        check("pend_rvalid_hold", {31'b0, rvalid}, 1);
        check("pend_rdata_hold", rdata, 32'h0000_3210);
        areset = 1'b1;
        @(posedge clk); #1;
        check("mid_rst_rvalid", {31'b0, rvalid}, 0);
        check("mid_rst_rdata", rdata, 0);
        areset = 1'b0;
        model_clear();
        repeat (3) begin
            @(posedge clk); #1;
            check("post_rst_no_resp", {31'b0, rvalid | bvalid}, 0);
        end
        for (int i = 0; i < 4; i++) read_check("post_rst_reg", 4'(i * 4));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
